// File: rtl/pair_match_checker.sv
// rtl/pair_match_checker.sv - memory-pairs turn loop: two picks, compare, hold, score tracking
// Optional attempt limit with LOST state enabled by defining ATTEMPT_LIMIT_EN.
module pair_match_checker #(
    parameter int         HOLD_CYCLES  = 4,
    parameter logic [7:0] MAX_ATTEMPTS = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] E,
    input  logic [3:0] F,
    input  logic       pick,
    input  logic [2:0] cardSel,
    output logic [3:0] revealVal,
    output logic       revealValid,
    output logic       matchPulse,
    output logic       missPulse,
    output logic [5:0] matchedMask,
    output logic [1:0] pairsFound,
    output logic [7:0] attempts,
    output logic       gameWon,
    output logic       gameLost
);

    typedef enum logic [2:0] {
        S_IDLE, S_FIRST, S_SECOND, S_COMPARE, S_HOLD, S_WON, S_LOST
    } state_t;

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

`ifdef ATTEMPT_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    state_t          state;
    logic [23:0]     cards;
    logic [2:0]      first_idx;
    logic [2:0]      second_idx;
    logic [3:0]      first_val;
    logic [3:0]      second_val;
    logic [CW-1:0]   hold_cnt;
    logic            limit_hit;

    logic [3:0]      sel_val;
    logic [7:0]      mask_ext;
    logic            pick_ok;
    logic [7:0]      att_inc;
    logic            is_match;
    logic [5:0]      pair_bits;

    always_comb begin
        sel_val = 4'd0;
        case (cardSel)
            3'd0:    sel_val = cards[3:0];
            3'd1:    sel_val = cards[7:4];
            3'd2:    sel_val = cards[11:8];
            3'd3:    sel_val = cards[15:12];
            3'd4:    sel_val = cards[19:16];
            3'd5:    sel_val = cards[23:20];
            default: sel_val = 4'd0;
        endcase
    end

    // Padding the mask to 8 bits lets out-of-range indices 6/7 be looked up safely.
    assign mask_ext  = {2'b00, matchedMask};
    assign pick_ok   = pick && (cardSel <= 3'd5) && !mask_ext[cardSel];
    assign att_inc   = (attempts == 8'hFF) ? attempts : attempts + 8'd1;
    assign is_match  = (first_val == second_val);
    assign pair_bits = (6'b1 << first_idx) | (6'b1 << second_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cards       <= '0;
            first_idx   <= '0;
            second_idx  <= '0;
            first_val   <= '0;
            second_val  <= '0;
            hold_cnt    <= '0;
            limit_hit   <= 1'b0;
            revealVal   <= '0;
            revealValid <= 1'b0;
            matchPulse  <= 1'b0;
            missPulse   <= 1'b0;
            matchedMask <= '0;
            pairsFound  <= '0;
            attempts    <= '0;
            gameWon     <= 1'b0;
            gameLost    <= 1'b0;
        end else begin
            matchPulse <= 1'b0;
            missPulse  <= 1'b0;
            if (load) begin
                cards       <= {F, E, D, C, B, A};
                matchedMask <= '0;
                pairsFound  <= '0;
                attempts    <= '0;
                revealValid <= 1'b0;
                gameWon     <= 1'b0;
                gameLost    <= 1'b0;
                limit_hit   <= 1'b0;
                state       <= S_FIRST;
            end else begin
                case (state)
                    S_FIRST: if (pick_ok) begin
                        first_idx   <= cardSel;
                        first_val   <= sel_val;
                        revealVal   <= sel_val;
                        revealValid <= 1'b1;
                        state       <= S_SECOND;
                    end
                    S_SECOND: if (pick_ok && (cardSel != first_idx)) begin
                        second_idx <= cardSel;
                        second_val <= sel_val;
                        revealVal  <= sel_val;
                        state      <= S_COMPARE;
                    end
                    S_COMPARE: begin
                        attempts <= att_inc;
                        if (is_match) begin
                            matchPulse  <= 1'b1;
                            matchedMask <= matchedMask | pair_bits;
                            pairsFound  <= pairsFound + 2'd1;
                        end else begin
                            missPulse <= 1'b1;
                        end
                        // Only a miss can exhaust the limit, so a game-completing match always wins.
                        limit_hit <= LIMIT_EN && !is_match && (att_inc == MAX_ATTEMPTS);
                        hold_cnt  <= HOLD_LAST;
                        state     <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (hold_cnt == '0) begin
                            revealValid <= 1'b0;
                            if (pairsFound == 2'd3) begin
                                gameWon <= 1'b1;
                                state   <= S_WON;
                            end else if (limit_hit) begin
                                gameLost <= 1'b1;
                                state    <= S_LOST;
                            end else begin
                                state <= S_FIRST;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pair_match_checker.sv
// tb/tb_pair_match_checker.sv - directed bench with compare-result scoreboard for pair_match_checker
module tb_pair_match_checker;
    localparam int HOLD = 4;
`ifdef ATTEMPT_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       pick = 1'b0;
    logic [2:0] cardSel = '0;
    logic [3:0] A = '0, B = '0, C = '0, D = '0, E = '0, F = '0;
    logic [3:0] revealVal;
    logic       revealValid, matchPulse, missPulse, gameWon, gameLost;
    logic [5:0] matchedMask;
    logic [1:0] pairsFound;
    logic [7:0] attempts;

    always #5 clk = ~clk;

    pair_match_checker #(.HOLD_CYCLES(HOLD), .MAX_ATTEMPTS(8'd2)) dut (
        .clk(clk), .rst(rst), .load(load),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
        .pick(pick), .cardSel(cardSel),
        .revealVal(revealVal), .revealValid(revealValid),
        .matchPulse(matchPulse), .missPulse(missPulse),
        .matchedMask(matchedMask), .pairsFound(pairsFound), .attempts(attempts),
        .gameWon(gameWon), .gameLost(gameLost)
    );

    typedef struct packed {
        logic       match;
        logic [5:0] mask;
        logic [1:0] pairs;
        logic [7:0] att;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         pushed = 0;
    logic [3:0] mc[6];
    logic [5:0] m_mask;
    logic [1:0] m_pairs;
    logic [7:0] m_att;
    int         m_first;
    logic       m_lost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && (matchPulse || missPulse)) begin
            pulses++;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed=%0b%0b expected=none", matchPulse, missPulse);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_match", matchPulse, e.match);
                chk("sb_miss", missPulse, !e.match);
                chk("sb_mask", matchedMask, e.mask);
                chk("sb_pairs", pairsFound, e.pairs);
                chk("sb_attempts", attempts, e.att);
            end
        end
    end

    task automatic set_cards(input logic [3:0] a, b, c, d, e, f);
        A = a; B = b; C = c; D = d; E = e; F = f;
        mc[0] = a; mc[1] = b; mc[2] = c; mc[3] = d; mc[4] = e; mc[5] = f;
        m_mask = '0; m_pairs = '0; m_att = '0; m_lost = 1'b0;
    endtask

    task automatic load_cards(input logic [3:0] a, b, c, d, e, f);
        set_cards(a, b, c, d, e, f);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic first_pick(input int i);
        pick = 1'b1; cardSel = 3'(i);
        @(negedge clk);
        pick = 1'b0;
        chk("first_val", revealVal, mc[i]);
        chk("first_valid", revealValid, 1'b1);
        m_first = i;
    endtask

    task automatic bad_pick(input int i, input logic expv, input logic [3:0] expval);
        pick = 1'b1; cardSel = 3'(i);
        @(negedge clk);
        pick = 1'b0;
        chk("ignore_valid", revealValid, expv);
        chk("ignore_val", revealVal, expval);
    endtask

    task automatic second_pick(input int i, input bit wait_hold);
        logic m;
        pick = 1'b1; cardSel = 3'(i);
        @(negedge clk);
        pick = 1'b0;
        chk("second_val", revealVal, mc[i]);
        m = (mc[m_first] == mc[i]);
        m_att = (m_att == 8'hFF) ? m_att : m_att + 8'd1;
        if (m) begin
            m_mask = m_mask | (6'b1 << m_first) | (6'b1 << i);
            m_pairs = m_pairs + 2'd1;
        end
        m_lost = LIM && !m && (m_att == 8'd2);
        q.push_back('{m, m_mask, m_pairs, m_att});
        pushed++;
        if (wait_hold) begin
            repeat (HOLD) @(negedge clk);
            chk("hold_valid", revealValid, 1'b1);
            chk("hold_won", gameWon, 1'b0);
            @(negedge clk);
            chk("post_hold_valid", revealValid, 1'b0);
            chk("post_hold_won", gameWon, m_pairs == 2'd3);
            chk("post_hold_lost", gameLost, m_lost);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_val", revealVal, 4'd0);
        chk("rst_valid", revealValid, 1'b0);
        chk("rst_match", matchPulse, 1'b0);
        chk("rst_miss", missPulse, 1'b0);
        chk("rst_mask", matchedMask, 6'd0);
        chk("rst_pairs", pairsFound, 2'd0);
        chk("rst_att", attempts, 8'd0);
        chk("rst_won", gameWon, 1'b0);
        chk("rst_lost", gameLost, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        bad_pick(0, 1'b0, 4'd0);

        // Game 1: full win with invalid picks interleaved
        load_cards(4'd1, 4'd2, 4'd1, 4'd3, 4'd2, 4'd3);
        chk("load_valid", revealValid, 1'b0);
        bad_pick(6, 1'b0, 4'd0);
        first_pick(0);
        bad_pick(0, 1'b1, 4'd1);
        bad_pick(6, 1'b1, 4'd1);
        second_pick(2, 1'b1);
        chk("g1_mask", matchedMask, 6'b000101);
        chk("g1_pairs", pairsFound, 2'd1);
        chk("g1_att", attempts, 8'd1);
        bad_pick(0, 1'b0, 4'd1);
        bad_pick(2, 1'b0, 4'd1);
        first_pick(1);
        second_pick(4, 1'b1);
        first_pick(3);
        second_pick(5, 1'b1);
        chk("won_att", attempts, 8'd3);
        chk("won_pairs", pairsFound, 2'd3);
        chk("won_mask", matchedMask, 6'b111111);
        bad_pick(0, 1'b0, 4'd3);
        chk("won_stays", gameWon, 1'b1);

        // Game 2: miss, then load during HOLD with a simultaneous pick
        load_cards(4'd4, 4'd9, 4'd4, 4'd7, 4'd9, 4'd7);
        chk("g2_won_clr", gameWon, 1'b0);
        chk("g2_mask_clr", matchedMask, 6'd0);
        first_pick(0);
        second_pick(1, 1'b1);
        chk("g2_miss_mask", matchedMask, 6'd0);
        chk("g2_miss_att", attempts, 8'd1);
        first_pick(2);
        second_pick(3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        set_cards(4'd8, 4'd8, 4'd12, 4'd12, 4'd15, 4'd15);
        load = 1'b1; pick = 1'b1; cardSel = 3'd1;
        @(negedge clk);
        load = 1'b0; pick = 1'b0;
        chk("reload_att", attempts, 8'd0);
        chk("reload_pairs", pairsFound, 2'd0);
        chk("reload_valid", revealValid, 1'b0);
        first_pick(1);

        // Game 3: two misses against the limit of 2
        second_pick(2, 1'b1);
        first_pick(1);
        second_pick(3, 1'b1);
        pick = 1'b1; cardSel = 3'd0;
        @(negedge clk);
        pick = 1'b0;
        chk("limit_valid", revealValid, !LIM);
        chk("limit_val", revealVal, LIM ? 4'd12 : 4'd8);
        chk("limit_lost", gameLost, LIM);

        // Asynchronous reset mid-turn
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_val", revealVal, 4'd0);
        chk("arst_valid", revealValid, 1'b0);
        chk("arst_att", attempts, 8'd0);
        chk("arst_lost", gameLost, 1'b0);
        chk("arst_pulse", {matchPulse, missPulse}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        bad_pick(0, 1'b0, 4'd0);

        chk("sb_empty", q.size(), 0);
        chk("pulse_count", pulses, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pair_match_checker.md
# pair_match_checker

Game-logic stage directly downstream of the memory-pairs card generator. Latches the six 4-bit card values (A–F) when the generator signals completion, then runs the player turn loop: two card picks, compare, match/miss indication, a display hold and score/attempt tracking until all three pairs are found. Outputs drive the seven-segment reveal and the status LEDs.

## Interface
- HOLD_CYCLES, 4: cycles the compare result and revealed cards stay displayed before the next turn (≥1).
- MAX_ATTEMPTS, 8'd10: attempt limit, used only when ATTEMPT_LIMIT_EN is defined.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse (generator endState); latches A–F and starts a new game.
- A, B, C, D, E, F  in  4 each  card values for card indices 0–5.
- pick  in  1  one-cycle pulse: player selects card cardSel.
- cardSel  in  3  selected card index, valid 0–5.
- revealVal  out  4  value of the most recently accepted pick.
- revealValid  out  1  high while at least one card of the current turn is face-up.
- matchPulse  out  1  one-cycle pulse: turn matched.
- missPulse  out  1  one-cycle pulse: turn missed.
- matchedMask  out  6  bit i set once card i is part of a found pair.
- pairsFound  out  2  pairs found, 0–3.
- attempts  out  8  completed turns, saturating at 255.
- gameWon  out  1  high in WON state.
- gameLost  out  1  high in LOST state (tied 0 without ATTEMPT_LIMIT_EN).

## Operation
- States: IDLE (no cards), FIRST, SECOND, COMPARE, HOLD, WON, LOST.
- Reset: state IDLE; all outputs 0; card registers 0; first-pick index/value registers 0.
- load (any state, including mid-turn): latch A–F, clear matchedMask/pairsFound/attempts/revealValid, go FIRST. load beats a same-cycle pick (pick dropped).
- FIRST: valid pick (cardSel ≤ 5 and matchedMask[cardSel]==0) stores index and value, revealVal=card value, revealValid=1, go SECOND. Invalid pick ignored, no state change.
- SECOND: valid pick additionally requires cardSel ≠ first index; stores second value, revealVal updates, go COMPARE. Invalid picks ignored.
- COMPARE (exactly one cycle, picks ignored): attempts += 1 (saturating). Equal values → matchPulse, set both mask bits, pairsFound += 1. Else → missPulse. Go HOLD.
- HOLD: picks ignored; after HOLD_CYCLES cycles: revealValid=0, then WON if pairsFound==3, else FIRST.
- WON/LOST: terminal; only load or rst leaves.
- IDLE: picks ignored until load.

## Timing
- Accepted pick sampled at edge k: revealVal/revealValid updated after edge k.
- Second pick at edge k → COMPARE during cycle k..k+1; matchPulse/missPulse, mask, pairsFound, attempts all update at edge k+1, pulse high exactly one cycle.
- HOLD occupies HOLD_CYCLES cycles after edge k+1; next-turn pick first accepted at edge k+1+HOLD_CYCLES+... i.e. first edge with state FIRST.
- gameWon asserts at the edge ending the final HOLD; stays high.
- Asynchronous rst mid-turn clears everything immediately, no pulse emitted.

## Configuration
- ATTEMPT_LIMIT_EN defined: at COMPARE, if the turn misses and the incremented attempts == MAX_ATTEMPTS, go LOST after HOLD instead of FIRST; gameLost high in LOST. A match on the limiting attempt that completes the game → WON (win takes priority).
- Not defined: no LOST state, gameLost constant 0, attempts only saturates at 255.

## Test plan
- Cards A=1,B=2,C=1,D=3,E=2,F=3; load; pick 0 then 2 → matchPulse one cycle, matchedMask=000101, pairsFound=1, attempts=1.
- Same cards; pick 0 then 1 → missPulse, mask unchanged, revealValid drops after HOLD_CYCLES=4 cycles, back to FIRST.
- Invalid picks: cardSel=6, already-matched card 0, repeat of first index in SECOND → all ignored, state/revealVal unchanged.
- Full game: pairs (0,2),(1,4),(3,5) → pairsFound=3, gameWon=1 after final HOLD, attempts=3; further picks ignored.
- load asserted during HOLD with a simultaneous pick → new cards latched, counts cleared, state FIRST, pick dropped; rst low mid-SECOND → all outputs 0 immediately.
- ATTEMPT_LIMIT_EN, MAX_ATTEMPTS=2: two misses → gameLost=1 after second HOLD; without macro, same stimulus → FIRST, gameLost=0.
